// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    ITER   = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_e;

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/adder_32bits.sv
// 32-bit ripple-style adder with carry in/out; the only arithmetic unit of the sequencer.
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one shared adder handles abs, 32 shift-add/sub
// steps and sign fix-up, giving a fixed 37-cycle latency. WIDTH must be 32.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             c_lo_q, c_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_ci, add_co;
  logic             is_div, accept, sa, sb;
  logic [WIDTH-1:0] div_sh;

  assign is_div = op_q[2];
  assign div_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));
  assign sa     = rs1[WIDTH-1] && op_signed_a(op);
  assign sb     = rs2[WIDTH-1] && op_signed_b(op);

  adder_32bits u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    unique case (state_q)
      ABS_A: begin
        add_a  = neg_a_q ? ~lo_q : lo_q;
        add_ci = neg_a_q;
      end
      ABS_B: begin
        add_a  = neg_b_q ? ~lo_q : lo_q;
        add_ci = neg_b_q;
      end
      ITER: begin
        if (is_div) begin
          add_a  = div_sh;
          add_b  = ~mc_q;
          add_ci = 1'b1;
        end else begin
          add_a = hi_q;
          add_b = lo_q[0] ? mc_q : '0;
        end
      end
      NEG_LO: begin
        add_a  = neg_lo_q ? ~lo_q : lo_q;
        add_ci = neg_lo_q;
      end
      NEG_HI: begin
        add_a  = neg_hi_q ? ~hi_q : hi_q;
        add_ci = neg_hi_q && (is_div || c_lo_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    c_lo_d   = c_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      IDLE, DONE: state_d = IDLE;
      // Operands arrive as lo=rs1, mc=rs2; ABS_A/ABS_B rotate them so that
      // multiply ends with mc=|a|, lo=|b| and divide with lo=|a|, mc=|b|.
      ABS_A: begin
        mc_d    = add_s;
        lo_d    = mc_q;
        state_d = ABS_B;
      end
      ABS_B: begin
        if (is_div) begin
          lo_d = mc_q;
          mc_d = add_s;
        end else begin
          lo_d = add_s;
        end
        hi_d    = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (is_div) begin
          if (hi_q[WIDTH-1] || add_co) begin
            hi_d = add_s;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_sh;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = {add_co, add_s[WIDTH-1:1]};
          lo_d = {add_s[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) state_d = NEG_LO;
      end
      NEG_LO: begin
        lo_d    = add_s;
        c_lo_d  = neg_lo_q && add_co;
        state_d = NEG_HI;
      end
      NEG_HI: begin
        hi_d     = add_s;
        result_d = ((op_q == OP_MUL) || (is_div && !op_q[1])) ? lo_q : add_s;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d    = op;
      neg_a_d = sa;
      neg_b_d = sb;
      if (op[2]) begin
        neg_lo_d = (sa ^ sb) && (rs2 != '0);
        neg_hi_d = sa;
      end else begin
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa ^ sb;
      end
      c_lo_d  = 1'b0;
      lo_d    = rs1;
      mc_d    = rs2;
      hi_d    = '0;
      state_d = ABS_A;
    end

    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      c_lo_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      c_lo_q   <= c_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mc_q     <= mc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE) && (state_q != DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, 37-cycle timing, handshake, flush, reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passed = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) step();
  endtask

  // Issues one op and waits (bounded) for done; returns latency, busy-low count, result.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_low, output logic [31:0] res);
    int cyc;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    step();
    start = 1'b0;
    cyc = 1;
    busy_low = 0;
    while (!done && cyc < 80) begin
      if (!busy) busy_low++;
      step();
      cyc++;
    end
    lat = cyc;
    res = result;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
  endtask

  task automatic test_mul;
    int lat, bl; logic [31:0] r;
    idle(2);
    do_op(3'd0, 32'h00000007, 32'hFFFFFFFD, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFEB) $display("FAIL mul_result got %h want ffffffeb", r); else passed++;
    checks++; if (lat !== 37) $display("FAIL mul_latency got %0d want 37", lat); else passed++;
    checks++; if (bl !== 0) $display("FAIL mul_busy_low got %0d want 0", bl); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mul_busy_in_done got %b want 0", busy); else passed++;
  endtask

  task automatic test_mulh;
    int lat, bl; logic [31:0] r;
    idle(2);
    do_op(3'd1, 32'h80000000, 32'h80000000, lat, bl, r);
    checks++; if (r !== 32'h40000000) $display("FAIL mulh got %h want 40000000", r); else passed++;
    idle(1);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu got %h want fffffffe", r); else passed++;
    idle(1);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu got %h want ffffffff", r); else passed++;
  endtask

  task automatic test_div;
    int lat, bl; logic [31:0] r;
    idle(1);
    do_op(3'd4, 32'hFFFFFFF9, 32'h2, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFD) $display("FAIL div_neg got %h want fffffffd", r); else passed++;
    idle(1);
    do_op(3'd6, 32'hFFFFFFF9, 32'h2, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_neg got %h want ffffffff", r); else passed++;
    idle(1);
    do_op(3'd5, 32'd100, 32'd7, lat, bl, r);
    checks++; if (r !== 32'd14) $display("FAIL divu got %h want 0000000e", r); else passed++;
    idle(1);
    do_op(3'd7, 32'd100, 32'd7, lat, bl, r);
    checks++; if (r !== 32'd2) $display("FAIL remu got %h want 00000002", r); else passed++;
  endtask

  task automatic test_div_corner;
    int lat, bl; logic [31:0] r;
    idle(1);
    do_op(3'd5, 32'd5, 32'd0, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL divu_by0 got %h want ffffffff", r); else passed++;
    checks++; if (lat !== 37) $display("FAIL divu_by0_latency got %0d want 37", lat); else passed++;
    idle(1);
    do_op(3'd7, 32'd5, 32'd0, lat, bl, r);
    checks++; if (r !== 32'd5) $display("FAIL remu_by0 got %h want 00000005", r); else passed++;
    idle(1);
    do_op(3'd4, 32'hFFFFFFFB, 32'd0, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL div_by0 got %h want ffffffff", r); else passed++;
    idle(1);
    do_op(3'd6, 32'hFFFFFFFB, 32'd0, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFB) $display("FAIL rem_by0 got %h want fffffffb", r); else passed++;
    idle(1);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, lat, bl, r);
    checks++; if (r !== 32'h80000000) $display("FAIL div_ovf got %h want 80000000", r); else passed++;
    idle(1);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, lat, bl, r);
    checks++; if (r !== 32'h0) $display("FAIL rem_ovf got %h want 00000000", r); else passed++;
  endtask

  task automatic test_ignore_start;
    int cyc;
    idle(2);
    start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    step();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 80) begin
      if (cyc == 10) begin
        start = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc !== 37) $display("FAIL ignore_latency got %0d want 37", cyc); else passed++;
    checks++; if (result !== 32'd14) $display("FAIL ignore_result got %h want 0000000e", result); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bl; logic [31:0] r;
    idle(2);
    do_op(3'd0, 32'd6, 32'd7, lat, bl, r);
    checks++; if (r !== 32'd42) $display("FAIL b2b_first got %h want 0000002a", r); else passed++;
    do_op(3'd5, 32'd81, 32'd9, lat, bl, r);
    checks++; if (lat !== 37) $display("FAIL b2b_latency got %0d want 37", lat); else passed++;
    checks++; if (r !== 32'd9) $display("FAIL b2b_second got %h want 00000009", r); else passed++;
  endtask

  task automatic test_flush;
    int lat, bl, cyc, seen; logic [31:0] r;
    idle(2);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bl, r);
    idle(1);
    start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd5;
    step();
    start = 1'b0;
    repeat (11) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passed++;
    seen = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (done) seen++;
      step();
    end
    checks++; if (seen !== 0) $display("FAIL flush_no_done got %0d done cycles want 0", seen); else passed++;
    checks++; if (result !== 32'hFFFFFFFE) $display("FAIL flush_result got %h want fffffffe", result); else passed++;
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
    step();
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL flush_start_drop got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, bl; logic [31:0] r;
    idle(1);
    start = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    step();
    start = 1'b0;
    repeat (19) step();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL rstmid_result got %h want 0", result); else passed++;
    step();
    rst_n = 1'b1;
    idle(1);
    do_op(3'd4, 32'hFFFFFFF9, 32'h2, lat, bl, r);
    checks++; if (r !== 32'hFFFFFFFD) $display("FAIL rstmid_newop got %h want fffffffd", r); else passed++;
    checks++; if (lat !== 37) $display("FAIL rstmid_latency got %0d want 37", lat); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
    #23;
    rst_n = 1'b1;
    step();
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_corner();
    test_ignore_start();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
